instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory interface: owns the PC, drives the byte address to
//  instruction_memory (combinational read), and registers the returned word into the IF/ID
//  pipeline register. Handles stall hold, branch/jump redirect with wrong-path bubble, and halt
//  on the 0xFC000000 sentinel (opcode 6'b111111). Sits between hazard/branch logic and decode.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC loaded on reset
//  HALT_OPCODE   6'b111111      opcode[31:26] that halts fetch
//  BUBBLE_INSTR  32'h0000_0000  word written to IF/ID on flush/halt (nop)
// PORTS
//  clk                in   1   single clock, all state updates on rising edge
//  rst                in   1   synchronous, active-high reset
//  stall              in   1   hazard unit: hold PC and IF/ID
//  redirect_valid     in   1   branch/jump taken this cycle
//  redirect_pc        in   32  target byte address; bits [1:0] ignored
//  imem_address       out  32  byte address to instruction memory (= pc, combinational)
//  imem_instruction   in   32  word returned same cycle
//  imem_control       in   6   opcode field from memory
//  imem_func          in   6   funct field from memory
//  if_id_valid        out  1   IF/ID holds a real instruction
//  if_id_instruction  out  32  registered instruction
//  if_id_control      out  6   registered opcode
//  if_id_func         out  6   registered funct
//  if_id_pc           out  32  address of registered instruction
//  if_id_pc_plus4     out  32  if_id_pc + 4 (mod 2^32)
//  halted             out  1   fetch stopped on HALT_OPCODE
//  fetch_count        out  32  count of instructions delivered with valid=1, wraps
// BEHAVIOUR
//  - Reset (rst=1 at edge, overrides everything incl. mid-operation): pc=RESET_PC, state=FETCH,
//    if_id_valid=0, if_id_instruction=BUBBLE_INSTR, if_id_control=0, if_id_func=0, if_id_pc=0,
//    if_id_pc_plus4=0, halted=0, fetch_count=0.
//  - imem_address = pc always (also in HALTED). Latency: word at pc appears in IF/ID 1 cycle later.
//  - FSM: FETCH, HALTED. Per-edge priority: rst > redirect_valid > stall > halt detect > fetch.
//  - FETCH, redirect_valid=1: pc={redirect_pc[31:2],2'b00}; IF/ID <= bubble (valid=0,
//    instruction=BUBBLE_INSTR, control/func from bubble); stall ignored this cycle.
//  - FETCH, stall=1 (no redirect): pc, IF/ID, fetch_count unchanged.
//  - FETCH, imem_control==HALT_OPCODE: state->HALTED, halted=1, pc unchanged, IF/ID <= bubble;
//    halt word never reaches decode, fetch_count not incremented.
//  - FETCH, otherwise: IF/ID <= {valid=1, imem_instruction, imem_control, imem_func, pc, pc+4};
//    pc <= pc+4; fetch_count++.
//  - HALTED: pc and IF/ID(bubble) held; stall ignored. redirect_valid=1 (older branch resolving
//    after wrong-path halt) -> state FETCH, halted=0, pc=redirect target, IF/ID bubble.
//  - Arithmetic: all PC adds 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0. fetch_count wraps at 2^32.
//  - Simultaneous halt word + stall: stall wins, halt evaluated when stall drops.
// STRUCTURE
//  - Shared package cpu_pkg: OPC_HALT=6'b111111, INSTR_BUBBLE, WORD_BYTES=4, fetch_state_t enum
//    {FETCH, HALTED}, if_id_t struct (valid, instruction, control, func, pc, pc_plus4).
//  - One sub-module: if_id_pipe_reg (load/hold/flush register for if_id_t, sync reset).
//  - PC register, FSM and fetch_count stay in the top module.
// TESTING
//  1 Reset, memory words 0..3 = 0x2231_0005,0x2231_FFFF,0x2009_0000,0x200A_0000 -> imem_address
//    0,4,8,12 on cycles 0..3; IF/ID valid from cycle 1, if_id_pc=0 with 0x2231_0005, func=6'h05.
//  2 stall high 3 cycles at pc=8 -> imem_address stays 8, IF/ID and fetch_count frozen, resume at 12.
//  3 redirect_valid with redirect_pc=0x0000_0027 at pc=16 -> next pc=0x24, IF/ID valid=0 one
//    cycle, then if_id_pc=0x24; redirect+stall same cycle -> redirect taken.
//  4 Fetch 0xFC00_0000 at pc=0x44 -> halted=1 next cycle, pc stays 0x44, if_id_valid=0,
//    fetch_count = instructions delivered before halt (17 for words 0..16).
//  5 While HALTED, redirect to 0x3C -> halted=0, fetch restarts at 0x3C.
//  6 rst asserted mid-run at pc=0x20 with stall=1 -> next cycle pc=0, all outputs at reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path and the IF/ID pipeline register.
package cpu_pkg;

  localparam logic [5:0]  OPC_HALT     = 6'b111111;
  localparam logic [31:0] INSTR_BUBBLE = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES   = 32'd4;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instruction;
    logic [5:0]  control;
    logic [5:0]  func;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: synchronous reset, then flush > load > hold.
module if_id_pipe_reg
  import cpu_pkg::*;
#(
  parameter if_id_t RESET_VAL = '0,
  parameter if_id_t FLUSH_VAL = '0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_load,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else if (i_flush) begin
      r_q <= FLUSH_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, presents it to instruction memory, and loads the returned word
// into IF/ID, handling stall hold, redirect with a wrong-path bubble, and halt on a sentinel.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE  = OPC_HALT,
  parameter logic [31:0] BUBBLE_INSTR = INSTR_BUBBLE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic [5:0]  imem_control,
  input  logic [5:0]  imem_func,
  output logic        if_id_valid,
  output logic [31:0] if_id_instruction,
  output logic [5:0]  if_id_control,
  output logic [5:0]  if_id_func,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam if_id_t L_RESET_ENTRY = '{
    valid: 1'b0, instruction: BUBBLE_INSTR, control: 6'd0, func: 6'd0,
    pc: 32'd0, pc_plus4: 32'd0
  };
  // Wrong-path bubble decodes as the nop word itself, so its fields come from BUBBLE_INSTR.
  localparam if_id_t L_FLUSH_ENTRY = '{
    valid: 1'b0, instruction: BUBBLE_INSTR, control: BUBBLE_INSTR[31:26],
    func: BUBBLE_INSTR[5:0], pc: 32'd0, pc_plus4: 32'd0
  };

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_fetch_count;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_redirect_target;
  logic         w_halt_hit;
  logic         w_fetch;
  logic         w_flush;
  if_id_t       w_fetch_entry;
  if_id_t       w_if_id;

  assign w_pc_plus4        = r_pc + WORD_BYTES;
  assign w_redirect_target = redirect_pc & ~32'h0000_0003;
  assign w_halt_hit        = (imem_control == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH: begin
        if (!redirect_valid && !stall && w_halt_hit) begin
          w_state_next = HALTED;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          w_state_next = FETCH;
        end
      end
      default: w_state_next = FETCH;
    endcase
  end

  // Redirect outranks stall in both states; a halt is only recognised on an unstalled fetch.
  always_comb begin
    w_fetch = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      FETCH: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
        end else if (!stall) begin
          w_flush = w_halt_hit;
          w_fetch = !w_halt_hit;
        end
      end
      HALTED: begin
        w_flush = redirect_valid;
      end
      default: begin
        w_fetch = 1'b0;
        w_flush = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_target;
    end else if (w_fetch) begin
      r_pc <= w_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= 32'd0;
    end else if (w_fetch) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign w_fetch_entry = '{
    valid: 1'b1, instruction: imem_instruction, control: imem_control,
    func: imem_func, pc: r_pc, pc_plus4: w_pc_plus4
  };

  if_id_pipe_reg #(
    .RESET_VAL (L_RESET_ENTRY),
    .FLUSH_VAL (L_FLUSH_ENTRY)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_fetch),
    .i_flush (w_flush),
    .i_d     (w_fetch_entry),
    .o_q     (w_if_id)
  );

  assign imem_address      = r_pc;
  assign if_id_valid       = w_if_id.valid;
  assign if_id_instruction = w_if_id.instruction;
  assign if_id_control     = w_if_id.control;
  assign if_id_func        = w_if_id.func;
  assign if_id_pc          = w_if_id.pc;
  assign if_id_pc_plus4    = w_if_id.pc_plus4;
  assign halted            = (r_state == HALTED);
  assign fetch_count       = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table, hand-written corner
// sequences, and a randomized run against a rule-level reference model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic [5:0]  imem_control;
  logic [5:0]  imem_func;
  logic        if_id_valid;
  logic [31:0] if_id_instruction;
  logic [5:0]  if_id_control;
  logic [5:0]  if_id_func;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic        m_halted;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  assign imem_instruction = mem[imem_address[7:2]];
  assign imem_control     = imem_instruction[31:26];
  assign imem_func        = imem_instruction[5:0];

  instruction_fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem_address      (imem_address),
    .imem_instruction  (imem_instruction),
    .imem_control      (imem_control),
    .imem_func         (imem_func),
    .if_id_valid       (if_id_valid),
    .if_id_instruction (if_id_instruction),
    .if_id_control     (if_id_control),
    .if_id_func        (if_id_func),
    .if_id_pc          (if_id_pc),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .halted            (halted),
    .fetch_count       (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Rules applied in priority order: reset, redirect, halted hold, stall, halt word, fetch.
  task automatic model_step();
    logic [31:0] word;
    word = mem[m_pc[7:2]];
    if (rst) begin
      m_pc = 32'd0; m_valid = 1'b0; m_instr = 32'd0; m_ifpc = 32'd0;
      m_halted = 1'b0; m_count = 32'd0;
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00}; m_valid = 1'b0; m_instr = 32'd0; m_halted = 1'b0;
    end else if (m_halted || stall) begin
      // nothing moves
    end else if (word[31:26] == 6'b111111) begin
      m_halted = 1'b1; m_valid = 1'b0; m_instr = 32'd0;
    end else begin
      m_valid = 1'b1; m_instr = word; m_ifpc = m_pc;
      m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int cyc_no);
    string tag;
    tag = $sformatf("rand%0d", cyc_no);
    chk({tag, ".addr"},   imem_address, m_pc);
    chk({tag, ".valid"},  {31'd0, if_id_valid}, {31'd0, m_valid});
    chk({tag, ".instr"},  if_id_instruction, m_instr);
    chk({tag, ".ctrl"},   {26'd0, if_id_control}, {26'd0, m_instr[31:26]});
    chk({tag, ".func"},   {26'd0, if_id_func}, {26'd0, m_instr[5:0]});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    chk({tag, ".count"},  fetch_count, m_count);
    if (m_valid) begin
      chk({tag, ".ifpc"}, if_id_pc, m_ifpc);
      chk({tag, ".pc4"},  if_id_pc_plus4, m_ifpc + 32'd4);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ifpc;
    logic [31:0] e_instr;
    logic [31:0] e_count;
    logic        e_halted;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_pc = 32'd0; m_valid = 1'b0; m_instr = 32'd0; m_ifpc = 32'd0;
    m_halted = 1'b0; m_count = 32'd0;

    mem[0] = 32'h2231_0005; mem[1] = 32'h2231_FFFF;
    mem[2] = 32'h2009_0000; mem[3] = 32'h200A_0000;
    for (int i = 4; i < 64; i++) mem[i] = 32'h2100_0000 + 32'(i) * 32'h0001_0001;
    mem[17] = 32'hFC00_0000;
    mem[63] = 32'h1234_5678;

    //         rst   stall rv    rpc            addr        vld   ifpc        instr          cnt  hlt
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h00,     1'b0, 32'h00,     32'h0,         0,   1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h04,     1'b1, 32'h00,     32'h2231_0005, 1,   1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h08,     1'b1, 32'h04,     32'h2231_FFFF, 2,   1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h08,     1'b1, 32'h04,     32'h2231_FFFF, 2,   1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h08,     1'b1, 32'h04,     32'h2231_FFFF, 2,   1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h08,     1'b1, 32'h04,     32'h2231_FFFF, 2,   1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0C,     1'b1, 32'h08,     32'h2009_0000, 3,   1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h10,     1'b1, 32'h0C,     32'h200A_0000, 4,   1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 32'h0000_0027, 32'h24,     1'b0, 32'h00,     32'h0,         4,   1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h28,     1'b1, 32'h24,     32'h2109_0009, 5,   1'b0};

    for (int i = 0; i < 10; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cyc(tbl[i].rst, tbl[i].stall, tbl[i].rv, tbl[i].rpc);
      chk({t, ".addr"},   imem_address, tbl[i].e_addr);
      chk({t, ".valid"},  {31'd0, if_id_valid}, {31'd0, tbl[i].e_valid});
      chk({t, ".instr"},  if_id_instruction, tbl[i].e_instr);
      chk({t, ".ctrl"},   {26'd0, if_id_control}, {26'd0, tbl[i].e_instr[31:26]});
      chk({t, ".func"},   {26'd0, if_id_func}, {26'd0, tbl[i].e_instr[5:0]});
      chk({t, ".count"},  fetch_count, tbl[i].e_count);
      chk({t, ".halted"}, {31'd0, halted}, {31'd0, tbl[i].e_halted});
      if (tbl[i].e_valid) begin
        chk({t, ".ifpc"}, if_id_pc, tbl[i].e_ifpc);
        chk({t, ".pc4"},  if_id_pc_plus4, tbl[i].e_ifpc + 32'd4);
      end
    end

    // Halt sentinel at 0x44 after 17 deliveries; stall holds it off first.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("halt.pre_addr", imem_address, 32'h44);
    chk("halt.pre_count", fetch_count, 32'd17);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("halt.stall_wins", {31'd0, halted}, 32'd0);
    chk("halt.stall_addr", imem_address, 32'h44);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("halt.halted", {31'd0, halted}, 32'd1);
    chk("halt.addr", imem_address, 32'h44);
    chk("halt.valid", {31'd0, if_id_valid}, 32'd0);
    chk("halt.instr", if_id_instruction, 32'h0);
    chk("halt.count", fetch_count, 32'd17);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("halt.hold", {31'd0, halted}, 32'd1);
    chk("halt.hold_addr", imem_address, 32'h44);

    // Redirect out of HALTED to 0x3C.
    cyc(1'b0, 1'b0, 1'b1, 32'h3C);
    chk("resume.halted", {31'd0, halted}, 32'd0);
    chk("resume.addr", imem_address, 32'h3C);
    chk("resume.valid", {31'd0, if_id_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("resume.valid2", {31'd0, if_id_valid}, 32'd1);
    chk("resume.ifpc", if_id_pc, 32'h3C);
    chk("resume.instr", if_id_instruction, 32'h210F_000F);
    chk("resume.count", fetch_count, 32'd18);
    chk("resume.addr2", imem_address, 32'h40);

    // PC wrap at the top of the address space.
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap.addr", imem_address, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap.ifpc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4", if_id_pc_plus4, 32'h0);
    chk("wrap.addr2", imem_address, 32'h0);
    chk("wrap.instr", if_id_instruction, 32'h1234_5678);

    // Reset mid-run at pc=0x20 with stall asserted.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mrst.pre_addr", imem_address, 32'h20);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mrst.addr", imem_address, 32'h0);
    chk("mrst.valid", {31'd0, if_id_valid}, 32'd0);
    chk("mrst.instr", if_id_instruction, 32'h0);
    chk("mrst.ctrl", {26'd0, if_id_control}, 32'd0);
    chk("mrst.func", {26'd0, if_id_func}, 32'd0);
    chk("mrst.ifpc", if_id_pc, 32'h0);
    chk("mrst.pc4", if_id_pc_plus4, 32'h0);
    chk("mrst.halted", {31'd0, halted}, 32'd0);
    chk("mrst.count", fetch_count, 32'd0);

    // Randomized run against the reference model.
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 15) == 0) mem[i] = 32'hFC00_0000;
      else mem[i] = $urandom & 32'hF7FF_FFFF;
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check_model(0);
    for (int i = 1; i <= 1500; i++) begin
      logic r;
      logic s;
      logic rv;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      cyc(r, s, rv, $urandom);
      check_model(i);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
